// File: rtl/mem_pkg.sv
// Shared encodings for the memory access controller.
// Funct3 sizes, FSM states and requester select values.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic SEL_IF = 1'b0;
    localparam logic SEL_D  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Requester and memory-side bus of the memory access controller.
// The master modport is the controller; slave is its environment.
interface mem_access_ctrl_if #(
    parameter int XLEN = 32
);
    logic            if_req;
    logic [XLEN-1:0] if_addr;
    logic            if_ack;
    logic [XLEN-1:0] if_rdata;
    logic            d_req;
    logic            d_we;
    logic [2:0]      d_funct3;
    logic [XLEN-1:0] d_addr;
    logic [XLEN-1:0] d_wdata;
    logic            d_ack;
    logic [XLEN-1:0] d_rdata;
    logic            err;
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [3:0]      mem_wstrb;
    logic            mem_ready;
    logic [XLEN-1:0] mem_rdata;
    logic            busy;

    modport master (
        input  if_req, if_addr, d_req, d_we, d_funct3, d_addr, d_wdata,
        input  mem_ready, mem_rdata,
        output if_ack, if_rdata, d_ack, d_rdata, err, busy,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

    modport slave (
        output if_req, if_addr, d_req, d_we, d_funct3, d_addr, d_wdata,
        output mem_ready, mem_rdata,
        input  if_ack, if_rdata, d_ack, d_rdata, err, busy,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

endinterface

// File: rtl/mem_lane_fmt.sv
// Byte-lane formatting: store strobes/replication, load extraction
// and extension, and access legality for a 32-bit word memory.
module mem_lane_fmt
    import mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            is_data,
    input  logic            we,
    input  logic [2:0]      funct3,
    input  logic [1:0]      off,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata,
    output logic            legal,
    output logic [3:0]      wstrb,
    output logic [XLEN-1:0] st_data,
    output logic [XLEN-1:0] ld_data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Alignment and encoding legality of the access.
    always_comb begin
        legal = 1'b0;
        if (!is_data) begin
            legal = (off == 2'b00);
        end else begin
            unique case (funct3)
                F3_B:    legal = 1'b1;
                F3_BU:   legal = !we;
                F3_H:    legal = !off[0];
                F3_HU:   legal = !we && !off[0];
                F3_W:    legal = (off == 2'b00);
                default: legal = 1'b0;
            endcase
        end
    end

    // Store strobes and lane-replicated write data.
    always_comb begin
        wstrb   = 4'b1111;
        st_data = wdata;
        unique case (funct3[1:0])
            2'b00: begin
                wstrb   = 4'b0001 << off;
                st_data = {4{wdata[7:0]}};
            end
            2'b01: begin
                wstrb   = 4'b0011 << off;
                st_data = {2{wdata[15:0]}};
            end
            default: begin
                wstrb   = 4'b1111;
                st_data = wdata;
            end
        endcase
    end

    // Load lane selection and sign/zero extension.
    always_comb begin
        lane_b  = rdata[{off, 3'b000} +: 8];
        lane_h  = rdata[{off[1], 4'b0000} +: 16];
        ld_data = rdata;
        unique case (funct3)
            F3_B:    ld_data = {{24{lane_b[7]}}, lane_b};
            F3_BU:   ld_data = {24'b0, lane_b};
            F3_H:    ld_data = {{16{lane_h[15]}}, lane_h};
            F3_HU:   ld_data = {16'b0, lane_h};
            default: ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Shares one memory port between instruction fetch and data access.
// Data wins ties; all outputs come straight from registers.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    mem_access_ctrl_if.master bus
);

    localparam int CW = $clog2(TIMEOUT);

    state_t          state, state_n;
    logic            sel_q, sel_n;
    logic            we_q, we_n;
    logic [2:0]      f3_q, f3_n;
    logic [1:0]      off_q, off_n;
    logic [CW-1:0]   cnt_q, cnt_n;
    logic            req_q, req_n;
    logic            mwe_q, mwe_n;
    logic [XLEN-1:0] maddr_q, maddr_n;
    logic [XLEN-1:0] mwdata_q, mwdata_n;
    logic [3:0]      mstrb_q, mstrb_n;
    logic            if_ack_q, if_ack_n;
    logic            d_ack_q, d_ack_n;
    logic            err_q, err_n;
    logic [XLEN-1:0] if_rd_q, if_rd_n;
    logic [XLEN-1:0] d_rd_q, d_rd_n;
    logic            busy_q;

    logic            f_is_data, f_we, f_legal;
    logic [2:0]      f_f3;
    logic [1:0]      f_off;
    logic [3:0]      f_strb;
    logic [XLEN-1:0] f_st, f_ld, req_addr;

    // Formatter sees the incoming winner in IDLE, the latched one after.
    always_comb begin
        req_addr = bus.d_req ? bus.d_addr : bus.if_addr;
        if (state == IDLE) begin
            f_is_data = bus.d_req;
            f_we      = bus.d_req && bus.d_we;
            f_f3      = bus.d_req ? bus.d_funct3 : F3_W;
            f_off     = req_addr[1:0];
        end else begin
            f_is_data = (sel_q == SEL_D);
            f_we      = we_q;
            f_f3      = f3_q;
            f_off     = off_q;
        end
    end

    mem_lane_fmt #(.XLEN(XLEN)) u_fmt (
        .is_data (f_is_data),
        .we      (f_we),
        .funct3  (f_f3),
        .off     (f_off),
        .wdata   (bus.d_wdata),
        .rdata   (bus.mem_rdata),
        .legal   (f_legal),
        .wstrb   (f_strb),
        .st_data (f_st),
        .ld_data (f_ld)
    );

    // Next state and next values of every registered output.
    always_comb begin
        state_n  = state;
        sel_n    = sel_q;
        we_n     = we_q;
        f3_n     = f3_q;
        off_n    = off_q;
        cnt_n    = cnt_q;
        req_n    = req_q;
        mwe_n    = mwe_q;
        maddr_n  = maddr_q;
        mwdata_n = mwdata_q;
        mstrb_n  = mstrb_q;
        if_ack_n = 1'b0;
        d_ack_n  = 1'b0;
        err_n    = 1'b0;
        if_rd_n  = if_rd_q;
        d_rd_n   = d_rd_q;
        unique case (state)
            IDLE: begin
                if (bus.d_req || bus.if_req) begin
                    sel_n = bus.d_req ? SEL_D : SEL_IF;
                    we_n  = f_we;
                    f3_n  = f_f3;
                    off_n = f_off;
                    cnt_n = '0;
                    if (f_legal) begin
                        state_n  = BUSY;
                        req_n    = 1'b1;
                        mwe_n    = f_we;
                        maddr_n  = {req_addr[XLEN-1:2], 2'b00};
                        mwdata_n = f_we ? f_st : '0;
                        mstrb_n  = f_we ? f_strb : 4'b0000;
                    end else begin
                        state_n  = RESP;
                        err_n    = 1'b1;
                        d_ack_n  = bus.d_req;
                        if_ack_n = !bus.d_req;
                        if (bus.d_req) d_rd_n = '0;
                        else if_rd_n = '0;
                    end
                end
            end
            BUSY: begin
                if (bus.mem_ready || cnt_q == CW'(TIMEOUT - 1)) begin
                    state_n = RESP;
                    req_n   = 1'b0;
                    mwe_n   = 1'b0;
                    mstrb_n = 4'b0000;
                    err_n   = !bus.mem_ready;
                    if (sel_q == SEL_D) begin
                        d_ack_n = 1'b1;
                        d_rd_n  = (bus.mem_ready && !we_q) ? f_ld : '0;
                    end else begin
                        if_ack_n = 1'b1;
                        if_rd_n  = bus.mem_ready ? bus.mem_rdata : '0;
                    end
                end else begin
                    cnt_n = cnt_q + CW'(1);
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            sel_q    <= SEL_IF;
            we_q     <= 1'b0;
            f3_q     <= 3'b000;
            off_q    <= 2'b00;
            cnt_q    <= '0;
            req_q    <= 1'b0;
            mwe_q    <= 1'b0;
            maddr_q  <= '0;
            mwdata_q <= '0;
            mstrb_q  <= 4'b0000;
            if_ack_q <= 1'b0;
            d_ack_q  <= 1'b0;
            err_q    <= 1'b0;
            if_rd_q  <= '0;
            d_rd_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_n;
            sel_q    <= sel_n;
            we_q     <= we_n;
            f3_q     <= f3_n;
            off_q    <= off_n;
            cnt_q    <= cnt_n;
            req_q    <= req_n;
            mwe_q    <= mwe_n;
            maddr_q  <= maddr_n;
            mwdata_q <= mwdata_n;
            mstrb_q  <= mstrb_n;
            if_ack_q <= if_ack_n;
            d_ack_q  <= d_ack_n;
            err_q    <= err_n;
            if_rd_q  <= if_rd_n;
            d_rd_q   <= d_rd_n;
            busy_q   <= (state_n != IDLE);
        end
    end

    assign bus.mem_req   = req_q;
    assign bus.mem_we    = mwe_q;
    assign bus.mem_addr  = maddr_q;
    assign bus.mem_wdata = mwdata_q;
    assign bus.mem_wstrb = mstrb_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.err       = err_q;
    assign bus.if_rdata  = if_rd_q;
    assign bus.d_rdata   = d_rd_q;
    assign bus.busy      = busy_q;

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences the single shared memory port of the multicycle RV32I core between two requesters: instruction fetch (IorD=0) and load/store data access (IorD=1).
- Sits between control_unit/datapath and the unified memory.
- Arbitrates, formats store byte lanes, sign/zero-extends loads, flags misaligned or illegal accesses, and times out a hung memory.

Parameters:
- XLEN, 32, data/address width.
- TIMEOUT, 16, max cycles in BUSY waiting for mem_ready before an error response (≥2).

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held until if_ack.
- if_addr  in  XLEN  fetch address (PC).
- if_ack  out  1  one-cycle pulse; fetch complete.
- if_rdata  out  XLEN  instruction word, valid with if_ack.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1=store, 0=load.
- d_funct3  in  3  access size/sign (RV32I load/store funct3).
- d_addr  in  XLEN  byte address.
- d_wdata  in  XLEN  store data, right-aligned.
- d_ack  out  1  one-cycle pulse; data access complete.
- d_rdata  out  XLEN  extended load result, valid with d_ack.
- err  out  1  valid with either ack; misaligned, illegal funct3 or timeout.
- mem_req  out  1  memory request, held until mem_ready.
- mem_we  out  1  memory write enable.
- mem_addr  out  XLEN  word address; byte address with [1:0] forced to 0.
- mem_wdata  out  XLEN  lane-replicated store data.
- mem_wstrb  out  4  byte write strobes; 0 on reads.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_rdata  in  XLEN  read data, valid with mem_ready.
- busy  out  1  high when state != IDLE.

Behaviour:
- Reset values: state IDLE; all acks, err, mem_req, mem_we, busy = 0; mem_wstrb = 0; addresses and data = 0. All outputs are registered.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - Sample requests. d_req has priority over if_req when both are high; the fetch stays pending.
  - Latch the winner's selection, address, we, funct3 and wdata.
  - Legal access: go to BUSY, mem_req=1 next cycle.
  - Illegal access: go straight to RESP with err=1 and no memory access.
- Illegal access definitions:
  - Fetch with if_addr[1:0] != 0.
  - Data with funct3 ∈ {011, 110, 111}, or with stores using funct3 ≥ 011.
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0] != 0.
- BUSY:
  - mem_req and its payload stay stable.
  - On a cycle with mem_ready=1: capture mem_rdata, drop mem_req, go to RESP.
  - Timeout counter: reset on entry, increment each BUSY cycle. If it reaches TIMEOUT-1 without mem_ready: drop mem_req, go to RESP with err=1.
- RESP:
  - Pulse the winner's ack for exactly one cycle, with rdata and err valid, then return to IDLE.
  - The other ack stays 0.
  - A request still high in the cycle after its ack is treated as new.
- Latency:
  - Request sampled at cycle N, mem_ready at cycle M ≥ N+1 gives ack at M+1.
  - Minimum is ack at N+2; an illegal access gives ack at N+1.
- Store formatting (off = addr[1:0]):
  - SB: mem_wstrb = 4'b0001 << off; mem_wdata = byte replicated ×4.
  - SH: mem_wstrb = 4'b0011 << off; mem_wdata = half replicated ×2.
  - SW: mem_wstrb = 4'b1111; mem_wdata = d_wdata.
- Load formatting: select byte/half lane by off.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- if_rdata = raw word.
- On err, rdata = 0.
- Requests arriving while not IDLE are ignored until IDLE; the requester must hold them.
- Reset asserted mid-transaction: next cycle is IDLE with mem_req=0 and no ack. Captured data is discarded; requesters re-issue.
- mem_ready while not in BUSY is ignored.

Decomposition:
- Shared package mem_pkg:
  - funct3 encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - State enum IDLE/BUSY/RESP.
  - Requester select constants SEL_IF/SEL_D.
- One sub-module, mem_lane_fmt: combinational store lane/strobe generation, load extraction/extension and the legality check. It is reused by a future cache.

Test Plan:
- Fetch: if_req=1, if_addr=0x0000_0010, mem_ready 1 cycle after mem_req, mem_rdata=0x015A04B3 -> mem_addr=0x10, mem_we=0; if_ack 2 cycles after sample; if_rdata=0x015A04B3; err=0.
- Simultaneous: if_req and d_req (LW 0x100) in the same cycle -> data served first, d_ack; fetch served next with if_ack; acks never overlap.
- Load extension:
  - LB at 0x103 with mem_rdata=0x80FF_FF7F -> d_rdata=0xFFFF_FF80.
  - LHU at 0x102 -> 0x0000_80FF.
- Store: SB at 0x201 with d_wdata=0xAB -> mem_wstrb=0010, mem_wdata=0xABAB_ABAB, mem_addr=0x200.
- Errors:
  - LW at 0x102 -> d_ack+err next cycle, mem_req never asserted.
  - mem_ready held 0 -> mem_req drops and d_ack+err after TIMEOUT cycles.
- Reset: reset pulsed while in BUSY -> mem_req=0, busy=0 next cycle; no ack; a re-issued fetch completes normally.
